// File: rtl/fetch_ibuf_ctrl.sv
// fetch_ibuf_ctrl: circular instruction buffer between 4-wide fetch/decode and dispatch.
// Takes 0-4 entries per cycle and presents up to DISP_W of the oldest entries to dispatch.
// num_fetch is the registered credit that tells fetch how many slots it may fill next cycle.
// is_jump flushes the whole buffer.
// Optional feature: define IB_ERR_CHECK_EN to build the sticky protocol checker that drives ib_err.
// When the macro is undefined, ib_err is tied low.
module fetch_ibuf_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ENTRY_W = 16,
  parameter int unsigned DISP_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         is_jump,
  input  logic [2:0]                   in_count,
  input  logic [4*ENTRY_W-1:0]         in_data_flat,
  input  logic [2:0]                   disp_take,
  output logic [2:0]                   num_fetch,
  output logic [DISP_W*ENTRY_W-1:0]    out_data_flat,
  output logic [2:0]                   out_count,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         ib_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = $clog2(DEPTH+1);
  localparam int unsigned FETCH_W = 4;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  logic [2:0]         in_cl;
  logic [2:0]         take_cl;
  logic [2:0]         w_cnt;
  logic [2:0]         t_cnt;
  logic [OCC_W-1:0]   free_now;
  logic [OCC_W-1:0]   occ_next;
  logic [OCC_W-1:0]   free_next;
  logic [2:0]         nf_next;

  // Valid output slots: min(occ, DISP_W), always contiguous from slot 0
  assign out_count = (occ < OCC_W'(DISP_W)) ? 3'(occ) : 3'(DISP_W);

  // Accepted write/take counts and next occupancy/credit
  always_comb begin
    in_cl     = (in_count > 3'(FETCH_W)) ? 3'(FETCH_W) : in_count;
    take_cl   = (disp_take > 3'(DISP_W)) ? 3'(DISP_W) : disp_take;
    // free space is the start-of-cycle value; same-cycle takes do not make room
    free_now  = OCC_W'(DEPTH) - occ;
    w_cnt     = (OCC_W'(in_cl) > free_now) ? 3'(free_now) : in_cl;
    t_cnt     = (take_cl > out_count) ? out_count : take_cl;
    occ_next  = occ - OCC_W'(t_cnt) + OCC_W'(w_cnt);
    free_next = OCC_W'(DEPTH) - occ_next;
    nf_next   = (free_next > OCC_W'(FETCH_W)) ? 3'(FETCH_W) : 3'(free_next);
  end

  // Oldest DISP_W entries to dispatch; unused slots drive zero
  always_comb begin
    out_data_flat = '0;
    for (int j = 0; j < int'(DISP_W); j++) begin
      if (3'(j) < out_count) begin
        out_data_flat[ENTRY_W*(DISP_W-1-j) +: ENTRY_W] = mem[head + PTR_W'(j)];
      end
    end
  end

  // Pointer, occupancy and fetch-credit registers; redirect overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      num_fetch <= 3'(FETCH_W);
    end else if (is_jump) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      num_fetch <= 3'(FETCH_W);
    end else begin
      head      <= head + PTR_W'(t_cnt);
      tail      <= tail + PTR_W'(w_cnt);
      occ       <= occ_next;
      num_fetch <= nf_next;
    end
  end

  // Storage writes; pointer arithmetic wraps so groups straddling DEPTH-1 split naturally
  always_ff @(posedge clk) begin
    if (rst_n && !is_jump) begin
      for (int i = 0; i < int'(FETCH_W); i++) begin
        if (3'(i) < w_cnt) begin
          mem[tail + PTR_W'(i)] <= in_data_flat[ENTRY_W*(FETCH_W-1-i) +: ENTRY_W];
        end
      end
    end
  end

`ifdef IB_ERR_CHECK_EN
  logic err_c;

  // Protocol violations judged on raw inputs, ignored during a redirect
  always_comb begin
    err_c = !is_jump &&
            ((in_count > num_fetch) ||
             (OCC_W'(in_count) > free_now) ||
             (disp_take > out_count));
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ib_err <= 1'b0;
    end else if (err_c) begin
      ib_err <= 1'b1;
    end
  end
`else
  assign ib_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ibuf_ctrl.sv
// Directed self-checking bench for fetch_ibuf_ctrl (DEPTH=16, ENTRY_W=16, DISP_W=2).
module tb_fetch_ibuf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        is_jump;
  logic [2:0]  in_count;
  logic [63:0] in_data_flat;
  logic [2:0]  disp_take;
  logic [2:0]  num_fetch;
  logic [31:0] out_data_flat;
  logic [2:0]  out_count;
  logic [4:0]  occ;
  logic        ib_err;

`ifdef IB_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_cmp;
  int n_fail;
  bit err_seen;

  fetch_ibuf_ctrl #(.DEPTH(16), .ENTRY_W(16), .DISP_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .is_jump       (is_jump),
    .in_count      (in_count),
    .in_data_flat  (in_data_flat),
    .disp_take     (disp_take),
    .num_fetch     (num_fetch),
    .out_data_flat (out_data_flat),
    .out_count     (out_count),
    .occ           (occ),
    .ib_err        (ib_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; outputs are sampled 1ns after the edge
  task automatic cycle(input logic j, input logic [2:0] ic, input logic [2:0] dt,
                       input logic [63:0] d);
    is_jump = j; in_count = ic; disp_take = dt; in_data_flat = d;
    @(posedge clk); #1;
    is_jump = 1'b0; in_count = 3'd0; disp_take = 3'd0; in_data_flat = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; is_jump = 1'b0; in_count = 3'd0; disp_take = 3'd0; in_data_flat = '0;
    err_seen = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (num_fetch !== 3'd4) begin n_fail++; $display("FAIL reset_num_fetch got %0d want 4", num_fetch); end
    n_cmp++; if (occ !== 5'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL reset_out_count got %0d want 0", out_count); end
    n_cmp++; if (out_data_flat !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data_flat); end
    n_cmp++; if (ib_err !== 1'b0) begin n_fail++; $display("FAIL reset_ib_err got %0b want 0", ib_err); end
    rst_n = 1'b1;
  endtask

  // Four groups of four fill the buffer; credit goes 4,4,4,0
  task automatic test_fill();
    logic [2:0] exp_nf;
    for (int g = 0; g < 4; g++) begin
      cycle(1'b0, 3'd4, 3'd0, {16'h1000 + 16'(4*g), 16'h1001 + 16'(4*g),
                               16'h1002 + 16'(4*g), 16'h1003 + 16'(4*g)});
      exp_nf = (g < 3) ? 3'd4 : 3'd0;
      n_cmp++; if (occ !== 5'(4*(g+1))) begin n_fail++; $display("FAIL fill_occ g=%0d got %0d want %0d", g, occ, 4*(g+1)); end
      n_cmp++; if (num_fetch !== exp_nf) begin n_fail++; $display("FAIL fill_num_fetch g=%0d got %0d want %0d", g, num_fetch, exp_nf); end
      n_cmp++; if (out_count !== 3'd2) begin n_fail++; $display("FAIL fill_out_count g=%0d got %0d want 2", g, out_count); end
      n_cmp++; if (out_data_flat !== 32'h1000_1001) begin n_fail++; $display("FAIL fill_out_data g=%0d got %h want 10001001", g, out_data_flat); end
    end
  endtask

  // Full buffer: a same-cycle take does not make room for the write
  task automatic test_full_take();
    cycle(1'b0, 3'd4, 3'd2, 64'hDEAD_DEAD_DEAD_DEAD);
    err_seen = 1'b1;
    n_cmp++; if (occ !== 5'd14) begin n_fail++; $display("FAIL full_take_occ got %0d want 14", occ); end
    n_cmp++; if (num_fetch !== 3'd2) begin n_fail++; $display("FAIL full_take_num_fetch got %0d want 2", num_fetch); end
    n_cmp++; if (out_data_flat !== 32'h1002_1003) begin n_fail++; $display("FAIL full_take_out_data got %h want 10021003", out_data_flat); end
    n_cmp++; if (ib_err !== (ERR_EN & err_seen)) begin n_fail++; $display("FAIL full_take_ib_err got %0b want %0b", ib_err, ERR_EN & err_seen); end
  endtask

  // Reset mid-operation, then steady 2-in/2-out with an odd tail so writes straddle 15->0
  task automatic test_wrap();
    logic [31:0] exp_d;
    apply_reset();
    n_cmp++; if (occ !== 5'd0) begin n_fail++; $display("FAIL midreset_occ got %0d want 0", occ); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL midreset_out_count got %0d want 0", out_count); end
    n_cmp++; if (ib_err !== 1'b0) begin n_fail++; $display("FAIL midreset_ib_err got %0b want 0", ib_err); end
    rst_n = 1'b1;
    cycle(1'b0, 3'd3, 3'd0, {16'h4000, 16'h4001, 16'h4002, 16'hFFFF});
    n_cmp++; if (occ !== 5'd3) begin n_fail++; $display("FAIL wrap_prefill_occ got %0d want 3", occ); end
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 3'd2, 3'd2, {16'h4003 + 16'(2*k), 16'h4004 + 16'(2*k), 32'hFFFF_FFFF});
      exp_d = {16'h4000 + 16'(2*k+2), 16'h4000 + 16'(2*k+3)};
      n_cmp++; if (out_data_flat !== exp_d) begin n_fail++; $display("FAIL wrap_out_data k=%0d got %h want %h", k, out_data_flat, exp_d); end
      n_cmp++; if (occ !== 5'd3) begin n_fail++; $display("FAIL wrap_occ k=%0d got %0d want 3", k, occ); end
      n_cmp++; if (num_fetch !== 3'd4) begin n_fail++; $display("FAIL wrap_num_fetch k=%0d got %0d want 4", k, num_fetch); end
    end
  endtask

  // Oversized in_count/disp_take are clamped to 4 and DISP_W
  task automatic test_clamp();
    cycle(1'b0, 3'd7, 3'd7, {16'h5000, 16'h5001, 16'h5002, 16'h5003});
    err_seen = 1'b1;
    n_cmp++; if (occ !== 5'd5) begin n_fail++; $display("FAIL clamp_occ got %0d want 5", occ); end
    n_cmp++; if (out_data_flat !== 32'h4016_5000) begin n_fail++; $display("FAIL clamp_out_data got %h want 40165000", out_data_flat); end
    n_cmp++; if (num_fetch !== 3'd4) begin n_fail++; $display("FAIL clamp_num_fetch got %0d want 4", num_fetch); end
    n_cmp++; if (ib_err !== (ERR_EN & err_seen)) begin n_fail++; $display("FAIL clamp_ib_err got %0b want %0b", ib_err, ERR_EN & err_seen); end
  endtask

  // Redirect at occ=9 empties the buffer; old entries never reappear
  task automatic test_flush();
    cycle(1'b0, 3'd4, 3'd0, {16'h5100, 16'h5101, 16'h5102, 16'h5103});
    n_cmp++; if (occ !== 5'd9) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 9", occ); end
    cycle(1'b1, 3'd4, 3'd2, {16'h5200, 16'h5201, 16'h5202, 16'h5203});
    n_cmp++; if (occ !== 5'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occ); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL flush_out_count got %0d want 0", out_count); end
    n_cmp++; if (num_fetch !== 3'd4) begin n_fail++; $display("FAIL flush_num_fetch got %0d want 4", num_fetch); end
    n_cmp++; if (out_data_flat !== 32'h0) begin n_fail++; $display("FAIL flush_out_data got %h want 0", out_data_flat); end
    cycle(1'b0, 3'd2, 3'd0, {16'h6000, 16'h6001, 32'hFFFF_FFFF});
    n_cmp++; if (out_data_flat !== 32'h6000_6001) begin n_fail++; $display("FAIL post_flush_out_data got %h want 60006001", out_data_flat); end
    n_cmp++; if (occ !== 5'd2) begin n_fail++; $display("FAIL post_flush_occ got %0d want 2", occ); end
    n_cmp++; if (ib_err !== (ERR_EN & err_seen)) begin n_fail++; $display("FAIL post_flush_ib_err got %0b want %0b", ib_err, ERR_EN & err_seen); end
  endtask

  // Take of 2 with one entry consumes exactly one; error flag sticks until reset
  task automatic test_underflow_take();
    apply_reset();
    n_cmp++; if (ib_err !== 1'b0) begin n_fail++; $display("FAIL uf_reset_ib_err got %0b want 0", ib_err); end
    rst_n = 1'b1;
    cycle(1'b0, 3'd1, 3'd0, {16'h7000, 48'hFFFF_FFFF_FFFF});
    n_cmp++; if (out_count !== 3'd1) begin n_fail++; $display("FAIL uf_out_count1 got %0d want 1", out_count); end
    n_cmp++; if (out_data_flat !== 32'h7000_0000) begin n_fail++; $display("FAIL uf_out_data got %h want 70000000", out_data_flat); end
    cycle(1'b0, 3'd0, 3'd2, 64'h0);
    err_seen = 1'b1;
    n_cmp++; if (occ !== 5'd0) begin n_fail++; $display("FAIL uf_occ got %0d want 0", occ); end
    n_cmp++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL uf_out_count0 got %0d want 0", out_count); end
    n_cmp++; if (num_fetch !== 3'd4) begin n_fail++; $display("FAIL uf_num_fetch got %0d want 4", num_fetch); end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 3'd0, 3'd0, 64'h0);
      n_cmp++; if (ib_err !== (ERR_EN & err_seen)) begin n_fail++; $display("FAIL uf_ib_err_hold k=%0d got %0b want %0b", k, ib_err, ERR_EN & err_seen); end
    end
    apply_reset();
    n_cmp++; if (ib_err !== 1'b0) begin n_fail++; $display("FAIL uf_ib_err_cleared got %0b want 0", ib_err); end
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; err_seen = 1'b0;
    rst_n = 1'b0; is_jump = 1'b0; in_count = 3'd0; disp_take = 3'd0; in_data_flat = '0;
    test_reset();
    test_fill();
    test_full_take();
    test_wrap();
    test_clamp();
    test_flush();
    test_underflow_take();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
